// File: rtl/ram_programmer.sv
// ram_programmer
//   Loads a byte stream into a single-port RAM while holding the CPU off the
//   bus, then reads the written range back and compares checksums.
//
//   Session: IDLE -start-> LOAD (write beats) -> VERIFY (read back)
//            -> FINISH (done pulse, pass/fail) -> IDLE
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request to begin a load session (IDLE only)
//   in_valid  in   load byte valid
//   in_data   in   load byte [DW]
//   in_last   in   final byte of the session
//   in_ready  out  block accepts a byte this cycle
//   ram_a     out  RAM address [AW]
//   ram_d     out  RAM write data [DW]
//   ram_we    out  RAM write enable
//   ram_q     in   RAM read data [DW], one cycle after the address
//   cpu_hold  out  keeps the CPU off the RAM bus during a session
//   busy      out  session in progress
//   done      out  one-cycle pulse at session end
//   pass      out  sticky: read-back checksum matched
//   fail      out  sticky: read-back checksum mismatched
//   count     out  bytes written in the last session [AW+1]
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is registered and is only high in LOAD; in_valid
// while in_ready is 0 is ignored. Each transfer becomes a one-cycle RAM
// write in the following cycle.
module ram_programmer #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [AW:0]   count
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] wsum_q, wsum_d;
    logic [DW-1:0] rsum_q, rsum_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   vcnt_q, vcnt_d;
    logic          last_q, last_d;      // final beat accepted, its write cycle is running
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_we_q, ram_we_d;
    logic          in_ready_q, in_ready_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            count_q    <= '0;
            vcnt_q     <= '0;
            last_q     <= 1'b0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            ram_we_q   <= 1'b0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            count_q    <= count_d;
            vcnt_q     <= vcnt_d;
            last_q     <= last_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        count_d    = count_q;
        vcnt_d     = vcnt_q;
        last_d     = last_q;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        ram_we_d   = 1'b0;
        in_ready_d = in_ready_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    ptr_d      = '0;
                    wsum_d     = '0;
                    rsum_d     = '0;
                    count_d    = '0;
                    last_d     = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    in_ready_d = 1'b1;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                if (last_q) begin
                    // Final write is on the bus this cycle; start read-back at 0.
                    state_d = VERIFY;
                    ram_a_d = '0;
                    vcnt_d  = '0;
                end else if (in_valid && in_ready_q) begin
                    ram_a_d  = ptr_q;
                    ram_d_d  = in_data;
                    ram_we_d = 1'b1;
                    ptr_d    = ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                    wsum_d   = wsum_q + in_data;
                    // Stop at in_last or at the top address; the pointer never wraps into use.
                    if (in_last || (ptr_q == PTR_LAST)) begin
                        in_ready_d = 1'b0;
                        last_d     = 1'b1;
                    end
                end
            end
            VERIFY: begin
                // Cycle k drives address k; ram_q for it arrives in cycle k+1,
                // so cycle 0 has nothing to add and cycle count adds the last word.
                vcnt_d = vcnt_q + CNT_ONE;
                if (vcnt_q != '0) begin
                    rsum_d = rsum_q + ram_q;
                end
                if ((vcnt_q + CNT_ONE) < count_q) begin
                    ram_a_d = ram_a_q + PTR_ONE;
                end
                if (vcnt_q == count_q) begin
                    state_d    = FINISH;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    busy_d     = 1'b0;
                    if (rsum_d == wsum_q) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = in_ready_q;
    assign ram_a    = ram_a_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = ram_we_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign count    = count_q;

endmodule

// File: tb/tb_ram_programmer.sv
// Bench for ram_programmer: a behavioural RAM (address captured on the
// rising edge, write and read data updated on the falling edge), directed
// load sessions, and a negedge monitor that pops expected RAM writes and
// expected session results from queues.
module tb_ram_programmer;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    ram_programmer #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .ram_a    (ram_a),
        .ram_d    (ram_d),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .count    (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- RAM model ----------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_addr;
    logic          corrupt;
    logic          fill_req;

    always @(posedge clk) rd_addr <= ram_a;

    always @(negedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hC3 ^ 8'(i);
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
        ram_q <= (corrupt && rd_addr == 4'd1) ? 8'h00 : mem[rd_addr];
    end

    // ---------------- scoreboard ----------------
    logic [11:0] wr_q   [$];   // {addr, data}
    logic [16:0] sess_q [$];   // {pass, fail, count[5], ram_we run[5], verify cycles[5]}
    logic [AW-1:0] wr_ptr;
    int run_cur, run_max, vcyc;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_cur = 0;
            run_max = 0;
            vcyc    = 0;
        end else begin
            checks++;
            if (pass && fail) begin
                errors++;
                $display("FAIL pass_fail_both got 1/1 want not both");
            end
            if (ram_we) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got a=%0h d=%0h want no write", ram_a, ram_d);
                end else begin
                    logic [11:0] e;
                    e = wr_q.pop_front();
                    if ({ram_a, ram_d} !== e) begin
                        errors++;
                        $display("FAIL ram_write got a=%0h d=%0h want a=%0h d=%0h",
                                 ram_a, ram_d, e[11:8], e[7:0]);
                    end
                end
                run_cur++;
                if (run_cur > run_max) run_max = run_cur;
            end else begin
                run_cur = 0;
            end
            if (busy && !in_ready && !ram_we) vcyc++;
            if (done) begin
                logic [16:0] act;
                act = {pass, fail, count, 5'(run_max), 5'(vcyc)};
                checks++;
                if (sess_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done=1 want no done");
                end else begin
                    logic [16:0] e;
                    e = sess_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL session got p=%0d f=%0d cnt=%0d run=%0d vcyc=%0d want p=%0d f=%0d cnt=%0d run=%0d vcyc=%0d",
                                 act[16], act[15], act[14:10], act[9:5], act[4:0],
                                 e[16], e[15], e[14:10], e[9:5], e[4:0]);
                    end
                end
                run_max = 0;
                vcyc    = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start  = 1'b0;
        wr_ptr = '0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        wr_q.push_back({wr_ptr, d});
        wr_ptr = wr_ptr + 4'd1;
        cyc(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_sess(input logic p, input logic f, input logic [4:0] c,
                             input logic [4:0] run, input logic [4:0] vc);
        sess_q.push_back({p, f, c, run, vc});
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        chk("session_timeout", {31'd0, busy}, 32'd0);
        cyc(1);
    endtask

    logic [DW-1:0] full_tbl [16] = '{8'h51, 8'h4E, 8'h50, 8'h4F, 8'hE0, 8'h1E, 8'h2F, 8'h4E,
                                    8'hE0, 8'h1F, 8'h2E, 8'h70, 8'h63, 8'h00, 8'h00, 8'h00};

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        corrupt = 1'b0; fill_req = 1'b1; wr_ptr = '0;
        #2;
        chk("rst_ram_we", {31'd0, ram_we}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_flags", {29'd0, done, pass, fail}, 0);
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_ram_a_d", {20'd0, ram_a, ram_d}, 0);
        cyc(2);
        fill_req = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Short load with gaps: AA, 55, FF(last)
        do_start();
        beat(8'hAA, 1'b0);
        cyc(1);
        chk("gap1_we", {31'd0, ram_we}, 0);
        chk("gap1_ready", {31'd0, in_ready}, 1);
        beat(8'h55, 1'b0);
        cyc(1);
        chk("gap2_we", {31'd0, ram_we}, 0);
        cyc(1);
        push_sess(1'b1, 1'b0, 5'd3, 5'd1, 5'd4);
        beat(8'hFF, 1'b1);
        chk("last_ready_drop", {31'd0, in_ready}, 0);
        wait_end();
        chk("short_wsum", {24'd0, dut.wsum_q}, 32'hFE);
        chk("short_mem0", {24'd0, mem[0]}, 32'hAA);
        chk("short_mem2", {24'd0, mem[2]}, 32'hFF);
        for (int i = 3; i < DEPTH; i++) chk("short_untouched", {24'd0, mem[i]}, {24'd0, 8'hC3 ^ 8'(i)});
        cyc(3);
        chk("pass_sticky", {30'd0, pass, fail}, 32'h2);

        // Full load, 16 back-to-back beats, no in_last
        do_start();
        chk("start_clears_pass", {30'd0, pass, fail}, 0);
        chk("start_clears_count", {27'd0, count}, 0);
        push_sess(1'b1, 1'b0, 5'd16, 5'd16, 5'd17);
        for (int i = 0; i < 16; i++) beat(full_tbl[i], 1'b0);
        chk("full_ready_drop", {31'd0, in_ready}, 0);
        wait_end();
        for (int i = 0; i < DEPTH; i++) chk("full_mem", {24'd0, mem[i]}, {24'd0, full_tbl[i]});

        // Corrupted read of address 1
        corrupt = 1'b1;
        do_start();
        push_sess(1'b0, 1'b1, 5'd3, 5'd3, 5'd4);
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b1);
        wait_end();
        corrupt = 1'b0;
        chk("corrupt_flags", {30'd0, pass, fail}, 32'h1);

        // Reset after the fifth beat's write
        do_start();
        for (int i = 1; i <= 5; i++) beat(8'(i), 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, ram_we}, 0);
        chk("arst_hold", {31'd0, cpu_hold}, 0);
        chk("arst_busy_ready", {30'd0, busy, in_ready}, 0);
        chk("arst_count", {27'd0, count}, 0);
        cyc(3);
        chk("arst_no_done", {31'd0, done}, 0);
        for (int i = 0; i < 5; i++) chk("arst_mem_kept", {24'd0, mem[i]}, i + 1);
        rst_n = 1'b1;
        cyc(1);
        do_start();
        push_sess(1'b1, 1'b0, 5'd4, 5'd4, 5'd5);
        beat(8'h0A, 1'b0);
        beat(8'h0B, 1'b0);
        beat(8'h0C, 1'b0);
        beat(8'h0D, 1'b1);
        wait_end();
        chk("post_rst_count", {27'd0, count}, 4);

        // Protocol abuse
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("idle_valid_ignored", {29'd0, in_ready, ram_we, busy}, 0);
        end
        in_valid = 1'b0;
        do_start();
        push_sess(1'b1, 1'b0, 5'd2, 5'd1, 5'd3);
        beat(8'h11, 1'b0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("load_start_ignored", {30'd0, busy, in_ready}, 32'h3);
        chk("load_start_count", {27'd0, count}, 1);
        beat(8'h22, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        wait_end();
        in_valid = 1'b0;
        chk("abuse_count", {27'd0, count}, 2);

        cyc(2);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("sess_q_empty", sess_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_programmer.md
RAM_PROGRAMMER -- requirements
Module: ram_programmer

Interface
REQ-001 Parameters SHALL be: AW, default 4, RAM address width; DW, default 8, RAM data width; DEPTH, fixed at 2**AW, number of words.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk  in  1  single system clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  1  one-cycle request to begin a load session.
  in_valid  in  1  load byte valid.
  in_data  in  DW  load byte.
  in_last  in  1  marks the final byte of the session.
  in_ready  out  1  block accepts a byte this cycle.
  ram_a  out  AW  RAM address.
  ram_d  out  DW  RAM write data.
  ram_we  out  1  RAM write enable.
  ram_q  in  DW  RAM read data; the RAM updates it on the falling clk edge.
  cpu_hold  out  1  holds the CPU off the RAM bus while a session is active.
  busy  out  1  session in progress.
  done  out  1  one-cycle pulse at session end.
  pass  out  1  sticky verify-OK flag.
  fail  out  1  sticky verify-mismatch flag.
  count  out  AW+1  number of bytes written in the last session.
REQ-003 All outputs SHALL be registered on rising clk.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, LOAD, VERIFY, FINISH.
REQ-005 IDLE: in_ready=0, ram_we=0, cpu_hold=0, busy=0.
  - start=1 -> LOAD next cycle.
  - On entry to LOAD: write pointer=0, wsum=0, rsum=0, count=0, pass=0, fail=0.
REQ-006 LOAD:
  - cpu_hold=1, busy=1, in_ready=1.
  - Each cycle with in_valid&in_ready, the block SHALL register ram_a=ptr, ram_d=in_data, ram_we=1 for exactly the following cycle.
  - The same accepted beat SHALL set ptr=ptr+1, count=count+1, and wsum=(wsum+in_data) mod 2**DW.
REQ-007 Back-to-back beats SHALL be accepted at one per cycle with no bubble; ram_we stays high across consecutive beats.
REQ-008 A cycle in LOAD without an accepted beat SHALL drive ram_we=0 in the next cycle.
REQ-009 The session boundary is the accepted beat with in_last=1 or ptr=DEPTH-1, whichever comes first.
  - in_ready SHALL drop in the cycle after that beat.
  - The FSM SHALL enter VERIFY after the final write cycle completes.
  - No address beyond DEPTH-1 is ever written; there is no wrap-around.
REQ-010 VERIFY:
  - ram_we=0, in_ready=0.
  - Drive ram_a=0..count-1, one address per cycle.
  - Read latency is 1 cycle: data for the address driven in cycle k SHALL be sampled from ram_q at the rising edge ending cycle k+1 and added to rsum mod 2**DW.
  - VERIFY SHALL last exactly count+1 cycles.
REQ-011 FINISH, one cycle:
  - done=1.
  - pass=1 if rsum==wsum, else fail=1.
  - cpu_hold and busy SHALL deassert in the same cycle.
  - Next state IDLE.
REQ-012 pass and fail SHALL hold until the next start is accepted; they are never both 1.
REQ-013 start SHALL be ignored outside IDLE; in_valid SHALL be ignored whenever in_ready=0.
REQ-014 in_data SHALL be written as-is; the block performs no data transformation.

Reset
REQ-015 rst_n=0 SHALL asynchronously force, with no clock required: state=IDLE, ram_we=0, in_ready=0, cpu_hold=0, busy=0, done=0, pass=0, fail=0, count=0, ram_a=0, ram_d=0.
REQ-016 Reset asserted mid-LOAD SHALL abort the session.
  - ram_we falls immediately.
  - Words already written remain in RAM.
  - No done pulse is produced.
REQ-017 After rst_n deasserts, the first accepted start SHALL behave identically to a start after power-up.

Verification
REQ-018 Full load: start; 16 back-to-back beats 0x51,0x4E,0x50,0x4F,0xE0,0x1E,0x2F,0x4E,0xE0,0x1F,0x2E,0x70,0x63,0,0,0, no in_last -> RAM[0..15] equal the beats; ram_we high for 16 consecutive cycles; VERIFY lasts 17 cycles; done pulse; pass=1; count=16.
REQ-019 Short load with gaps: 3 beats 0xAA, 0x55, 0xFF (0xFF with in_last), idle cycles between beats -> ram_we low in the idle cycles; count=3; wsum=0xFE; pass=1; RAM[3..15] untouched.
REQ-020 Corruption: RAM model forces ram_q=0x00 on the read of address 1 during VERIFY -> fail=1, pass=0, done pulses once.
REQ-021 Reset mid-load: assert rst_n=0 after beat 5 -> ram_we=0 and cpu_hold=0 without a clock edge; RAM[0..4] keep the written data; no done; a new start afterwards runs normally.
REQ-022 Protocol abuse: start pulsed during LOAD, and in_valid=1 during IDLE and VERIFY -> no state change, no extra RAM write, count unchanged.
